// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-source UART TX arbiter with per-source byte FIFOs (optional CRLF_EXPAND_EN)
// Scheduler grants the shared transmitter one byte at a time and sequences the tx_start/tx_busy handshake.

module uart_tx_arbiter_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
endmodule

module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       idle
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE
`ifdef CRLF_EXPAND_EN
        , S_LF_LOAD
`endif
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] head0;
    logic [7:0] head1;
    logic       empty0;
    logic       empty1;
    logic       full0;
    logic       full1;
    logic       push0;
    logic       push1;
    logic       pop0;
    logic       pop1;
    logic       win;
    logic       go;
    logic       rr_last;
    logic       grant_q;
    logic [7:0] tx_data_q;
`ifdef CRLF_EXPAND_EN
    logic       lf_pend;
`endif

    assign req0_ready = ~full0;
    assign req1_ready = ~full1;
    assign push0      = req0_valid & ~full0;
    assign push1      = req1_valid & ~full1;
    assign pop0       = (state == S_LOAD) & ~grant_q;
    assign pop1       = (state == S_LOAD) & grant_q;
    assign go         = ~tx_busy & ~(empty0 & empty1);

    uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk    (clk),
        .resetn (resetn),
        .push   (push0),
        .wdata  (req0_data),
        .pop    (pop0),
        .rdata  (head0),
        .empty  (empty0),
        .full   (full0)
    );

    uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk    (clk),
        .resetn (resetn),
        .push   (push1),
        .wdata  (req1_data),
        .pop    (pop1),
        .rdata  (head1),
        .empty  (empty1),
        .full   (full1)
    );

    // Winner is only meaningful when at least one FIFO holds data.
    always_comb begin
        win = 1'b0;
        if (FIXED_PRIO)
            win = empty0;
        else if (!empty0 && !empty1)
            win = ~rr_last;
        else
            win = empty0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (go) state_next = S_LOAD;
            S_LOAD:      state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy) state_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef CRLF_EXPAND_EN
                    state_next = lf_pend ? S_LF_LOAD : S_IDLE;
`else
                    state_next = S_IDLE;
`endif
                end
            end
`ifdef CRLF_EXPAND_EN
            S_LF_LOAD:   state_next = S_WAIT_BUSY;
`endif
            default:     state_next = S_IDLE;
        endcase
    end

    // Byte and source are latched at the IDLE decision so they are already valid during LOAD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q   <= 1'b0;
            tx_data_q <= 8'h00;
            rr_last   <= 1'b1;
`ifdef CRLF_EXPAND_EN
            lf_pend   <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE && go) begin
                grant_q   <= win;
                tx_data_q <= win ? head1 : head0;
            end
            if (state == S_LOAD) begin
                rr_last <= grant_q;
`ifdef CRLF_EXPAND_EN
                lf_pend <= ~grant_q && (tx_data_q == 8'h0D);
`endif
            end
`ifdef CRLF_EXPAND_EN
            if (state == S_WAIT_DONE && !tx_busy && lf_pend) begin
                tx_data_q <= 8'h0A;
                grant_q   <= 1'b0;
                lf_pend   <= 1'b0;
            end
`endif
        end
    end

    always_comb begin
        tx_start = (state == S_LOAD);
`ifdef CRLF_EXPAND_EN
        if (state == S_LF_LOAD) tx_start = 1'b1;
`endif
        idle = (state == S_IDLE) && empty0 && empty1;
    end

    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
endmodule
